delay_timer_arbiter: RTL

DELAY_TIMER_ARBITER -- requirements
Module: delay_timer_arbiter

---
 rtl/delay_timer_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter for four requesters sharing one prescaled delay timer.
// The winner's delay is latched at grant and counted down in base ticks of DIV clocks.
module delay_timer_arbiter #(
    parameter int DIV   = 50000000,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         req,
    input  logic [4*CNT_W-1:0] req_delay,
    input  logic               abort,
    output logic [3:0]         grant,
    output logic [3:0]         done,
    output logic               busy,
    output logic [CNT_W-1:0]   remaining
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [1:0]       ptr_reg;
    logic [1:0]       owner_reg;
    logic [PRE_W-1:0] pre_reg;
    logic [CNT_W-1:0] rem_reg;
    logic [3:0]       grant_reg;
    logic [3:0]       done_reg;
    logic             busy_reg;

    logic [CNT_W-1:0] delay_arr [4];
    logic             win_valid;
    logic [1:0]       win_idx;
    logic [1:0]       cand;
    logic [CNT_W-1:0] win_delay;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_delay
            assign delay_arr[gi] = req_delay[CNT_W*gi +: CNT_W];
        end
    endgenerate

    // Scan from the highest offset down so the candidate closest to ptr wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr_reg;
        cand      = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_reg + 2'(k);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_delay = delay_arr[win_idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            ptr_reg   <= 2'd0;
            owner_reg <= 2'd0;
            pre_reg   <= PRE_RELOAD;
            rem_reg   <= '0;
            grant_reg <= 4'b0000;
            done_reg  <= 4'b0000;
            busy_reg  <= 1'b0;
        end else begin
            done_reg <= 4'b0000;
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        owner_reg <= win_idx;
                        pre_reg   <= PRE_RELOAD;
                        busy_reg  <= 1'b1;
                        if (win_delay != '0) begin
                            state_reg <= RUN;
                            grant_reg <= 4'b0001 << win_idx;
                            rem_reg   <= win_delay;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 4'b0001 << win_idx;
                            rem_reg   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        grant_reg <= 4'b0000;
                        rem_reg   <= '0;
                        busy_reg  <= 1'b0;
                        pre_reg   <= PRE_RELOAD;
                        ptr_reg   <= owner_reg + 2'd1;
                    end else if (pre_reg == '0) begin
                        pre_reg <= PRE_RELOAD;
                        // remaining is always >= 1 in RUN; the 1 -> 0 step ends the run
                        if (rem_reg == CNT_W'(1)) begin
                            rem_reg   <= '0;
                            grant_reg <= 4'b0000;
                            state_reg <= DONE;
                            done_reg  <= 4'b0001 << owner_reg;
                        end else begin
                            rem_reg <= rem_reg - CNT_W'(1);
                        end
                    end else begin
                        pre_reg <= pre_reg - PRE_W'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    ptr_reg   <= owner_reg + 2'd1;
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= 4'b0000;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign grant     = grant_reg;
    assign done      = done_reg;
    assign busy      = busy_reg;
    assign remaining = rem_reg;

endmodule
